// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// ---------------
// Forwarding and hazard unit for a 5-stage pipeline (IF ID EX MEM WB).
//
// The unit compares the ID-stage source registers against the producer in EX
// (distance 1) and against its own shadow copy of the EX/MEM slot
// (distance 2). It uses that comparison to:
//   - produce registered forwarding controls for the instruction that enters
//     EX on the next clock;
//   - request a one-cycle stall/bubble for a load-use hazard, or when the two
//     operands would need two different forwarded values. There is only one
//     fwd_res path, so it cannot carry two values at once.
// The register file writes through, so WB-stage producers are never
// forwarded.
//
// Parameters:
//   DW  - datapath width
//   RAW - register address width
//
// Ports:
//   clk, rst         - rising-edge clock, asynchronous active-high reset
//   id_valid         - ID holds a live instruction
//   id_rs1, id_rs2   - ID source registers
//   id_use_rs1/rs2   - ID instruction actually reads rs1 / rs2 as ALU operands
//   ex_valid         - EX holds a live instruction
//   ex_write_reg     - EX destination register
//   ex_reg_wrenable  - EX instruction writes a register
//   ex_mem_to_reg    - EX instruction is a load
//   ex_alu_res       - EX ALU result
//   mem_rdata        - data-memory read data, valid during MEM
//   flush            - kill the ID instruction (taken branch/jump)
//   stall            - hold PC and IF/ID (combinational)
//   bubble           - load a NOP into ID/EX (combinational, equals stall)
//   fwd_a, fwd_b     - EX op1 / op2 take fwd_res (registered)
//   fwd_res          - forwarded value (registered)
//
// Optional feature, macro HAZARD_STATS_EN:
//   stats_clr        - synchronous clear of stall_count, wins over increment
//   stall_count      - saturating count of stalled cycles

module hazard_fwd_unit #(
    parameter int DW  = 32,
    parameter int RAW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [RAW-1:0] id_rs1,
    input  logic [RAW-1:0] id_rs2,
    input  logic           id_use_rs1,
    input  logic           id_use_rs2,
    input  logic           ex_valid,
    input  logic [RAW-1:0] ex_write_reg,
    input  logic           ex_reg_wrenable,
    input  logic           ex_mem_to_reg,
    input  logic [DW-1:0]  ex_alu_res,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           flush,
`ifdef HAZARD_STATS_EN
    input  logic           stats_clr,
    output logic [15:0]    stall_count,
`endif
    output logic           stall,
    output logic           bubble,
    output logic           fwd_a,
    output logic           fwd_b,
    output logic [DW-1:0]  fwd_res
);

    // Shadow of the EX/MEM pipeline slot.
    logic           m_v;
    logic           m_we;
    logic [RAW-1:0] m_dst;
    logic           m_load;
    logic [DW-1:0]  m_val;

    logic [DW-1:0]  dist2_val;
    logic           rs1_nz;
    logic           rs2_nz;
    logic           d1_1;
    logic           d1_2;
    logic           d2_1;
    logic           d2_2;
    logic           need_a;
    logic           need_b;
    logic           same_match;
    logic           load_use;
    logic           conflict;
    logic           hold_fwd;

    // The shadow slot follows EX unconditionally. A bubble shows up here as
    // ex_valid=0, so a stalled consumer sees its producer move one stage on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v    <= 1'b0;
            m_we   <= 1'b0;
            m_dst  <= '0;
            m_load <= 1'b0;
            m_val  <= '0;
        end else begin
            m_v    <= ex_valid;
            m_we   <= ex_reg_wrenable;
            m_dst  <= ex_write_reg;
            m_load <= ex_mem_to_reg;
            m_val  <= ex_alu_res;
        end
    end

    // A load in MEM only has its value on the memory read port.
    assign dist2_val = m_load ? mem_rdata : m_val;

    // Operand matching. x0 is hard-wired zero and never forwarded. When the
    // same register is produced in both EX and MEM, the EX producer is younger
    // and wins.
    assign rs1_nz = (id_rs1 != '0);
    assign rs2_nz = (id_rs2 != '0);

    assign d1_1 = id_use_rs1 & rs1_nz & ex_valid & ex_reg_wrenable & (ex_write_reg == id_rs1);
    assign d1_2 = id_use_rs2 & rs2_nz & ex_valid & ex_reg_wrenable & (ex_write_reg == id_rs2);
    assign d2_1 = id_use_rs1 & rs1_nz & m_v & m_we & (m_dst == id_rs1) & ~d1_1;
    assign d2_2 = id_use_rs2 & rs2_nz & m_v & m_we & (m_dst == id_rs2) & ~d1_2;

    assign need_a = d1_1 | d2_1;
    assign need_b = d1_2 | d2_2;

    // Both operands can share fwd_res only when they read the same register
    // from the same producer.
    assign same_match = ((d1_1 & d1_2) | (d2_1 & d2_2)) & (id_rs1 == id_rs2);
    assign conflict   = need_a & need_b & ~same_match;

    // A load in EX has no data yet. After one stall it sits in MEM and is
    // forwarded from mem_rdata.
    assign load_use = (d1_1 | d1_2) & ex_mem_to_reg;

    // Flush kills the ID instruction, so it never stalls.
    assign stall  = id_valid & ~flush & (load_use | conflict);
    assign bubble = stall;

    assign hold_fwd = stall | flush | ~id_valid;

    // Forwarding controls are registered, so they line up with the ID
    // instruction as it enters EX on the next cycle. fwd_res keeps its last
    // value whenever nothing new is selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a   <= 1'b0;
            fwd_b   <= 1'b0;
            fwd_res <= '0;
        end else if (hold_fwd) begin
            fwd_a   <= 1'b0;
            fwd_b   <= 1'b0;
        end else begin
            fwd_a <= need_a;
            fwd_b <= need_b;
            if (d1_1 | d1_2) begin
                fwd_res <= ex_alu_res;
            end else if (d2_1 | d2_2) begin
                fwd_res <= dist2_val;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating stall counter. stats_clr wins over an increment in the same
    // cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 16'd0;
        end else if (stats_clr) begin
            stall_count <= 16'd0;
        end else if (stall && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
// ------------------
// Directed self-checking bench for hazard_fwd_unit. Inputs change 1ns after a
// rising edge. Combinational outputs are checked 1ns after that. Registered
// outputs are checked 1ns after the following rising edge.

module tb_hazard_fwd_unit;

    localparam int DW  = 32;
    localparam int RAW = 5;

    logic           clk;
    logic           rst;
    logic           id_valid;
    logic [RAW-1:0] id_rs1;
    logic [RAW-1:0] id_rs2;
    logic           id_use_rs1;
    logic           id_use_rs2;
    logic           ex_valid;
    logic [RAW-1:0] ex_write_reg;
    logic           ex_reg_wrenable;
    logic           ex_mem_to_reg;
    logic [DW-1:0]  ex_alu_res;
    logic [DW-1:0]  mem_rdata;
    logic           flush;
    logic           stall;
    logic           bubble;
    logic           fwd_a;
    logic           fwd_b;
    logic [DW-1:0]  fwd_res;
`ifdef HAZARD_STATS_EN
    logic           stats_clr;
    logic [15:0]    stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_fwd_unit #(.DW(DW), .RAW(RAW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_valid        (ex_valid),
        .ex_write_reg    (ex_write_reg),
        .ex_reg_wrenable (ex_reg_wrenable),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_alu_res      (ex_alu_res),
        .mem_rdata       (mem_rdata),
        .flush           (flush),
`ifdef HAZARD_STATS_EN
        .stats_clr       (stats_clr),
        .stall_count     (stall_count),
`endif
        .stall           (stall),
        .bubble          (bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .fwd_res         (fwd_res)
    );

    // 10ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the EX-stage producer and the ID-stage consumer.
    task automatic applyStimulus(
        input logic           ev,
        input logic [RAW-1:0] ewr,
        input logic           ewe,
        input logic           eld,
        input logic [DW-1:0]  eres,
        input logic           iv,
        input logic [RAW-1:0] r1,
        input logic           u1,
        input logic [RAW-1:0] r2,
        input logic           u2,
        input logic           fl
    );
        ex_valid        = ev;
        ex_write_reg    = ewr;
        ex_reg_wrenable = ewe;
        ex_mem_to_reg   = eld;
        ex_alu_res      = eres;
        id_valid        = iv;
        id_rs1          = r1;
        id_use_rs1      = u1;
        id_rs2          = r2;
        id_use_rs2      = u2;
        flush           = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all inputs idle.
        rst       = 1'b1;
        mem_rdata = '0;
`ifdef HAZARD_STATS_EN
        stats_clr = 1'b0;
`endif
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        checkOutput("reset_fwd_a", fwd_a, 0);
        checkOutput("reset_fwd_b", fwd_b, 0);
        checkOutput("reset_fwd_res", fwd_res, 0);
        checkOutput("reset_stall", stall, 0);
        rst = 1'b0;
        stepClock();

        // ALU back-to-back: EX writes x5=0x11, ID reads rs1=x5.
        applyStimulus(1, 5, 1, 0, 32'h11, 1, 5, 1, 0, 0, 0);
        #1;
        checkOutput("alu_stall", stall, 0);
        stepClock();
        checkOutput("alu_fwd_a", fwd_a, 1);
        checkOutput("alu_fwd_b", fwd_b, 0);
        checkOutput("alu_fwd_res", fwd_res, 32'h11);

        // Load-use: EX loads x7, ID reads rs2=x7.
        applyStimulus(1, 7, 1, 1, 32'h700, 1, 0, 0, 7, 1, 0);
        #1;
        checkOutput("lu_stall", stall, 1);
        checkOutput("lu_bubble", bubble, 1);
        stepClock();
        checkOutput("lu_hold_fwd_b", fwd_b, 0);
        checkOutput("lu_hold_fwd_res", fwd_res, 32'h11);
        // Bubble now in EX, load in MEM with its data on mem_rdata.
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 7, 1, 0);
        mem_rdata = 32'hCAFE;
        #1;
        checkOutput("lu_release_stall", stall, 0);
        stepClock();
        checkOutput("lu_fwd_a", fwd_a, 0);
        checkOutput("lu_fwd_b", fwd_b, 1);
        checkOutput("lu_fwd_res", fwd_res, 32'hCAFE);
        mem_rdata = '0;

        // Dual conflict: MEM writes x4=0x4, EX writes x3=0x3, ID rs1=x3, rs2=x4.
        applyStimulus(1, 4, 1, 0, 32'h4, 0, 0, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 3, 1, 0, 32'h3, 1, 3, 1, 4, 1, 0);
        #1;
        checkOutput("dual_stall", stall, 1);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 1, 4, 1, 0);
        #1;
        checkOutput("dual_release_stall", stall, 0);
        stepClock();
        checkOutput("dual_fwd_a", fwd_a, 1);
        checkOutput("dual_fwd_b", fwd_b, 0);
        checkOutput("dual_fwd_res", fwd_res, 32'h3);

        // Same register on both operands: MEM x6=0x99, EX x6=0x66 (youngest wins).
        applyStimulus(1, 6, 1, 0, 32'h99, 0, 0, 0, 0, 0, 0);
        stepClock();
        applyStimulus(1, 6, 1, 0, 32'h66, 1, 6, 1, 6, 1, 0);
        #1;
        checkOutput("same_stall", stall, 0);
        stepClock();
        checkOutput("same_fwd_a", fwd_a, 1);
        checkOutput("same_fwd_b", fwd_b, 1);
        checkOutput("same_fwd_res", fwd_res, 32'h66);

        // x0 is never forwarded; fwd_res holds its last value.
        applyStimulus(1, 0, 1, 0, 32'h55, 1, 0, 1, 0, 0, 0);
        #1;
        checkOutput("x0_stall", stall, 0);
        stepClock();
        checkOutput("x0_fwd_a", fwd_a, 0);
        checkOutput("x0_fwd_res", fwd_res, 32'h66);

        // Flush wins over a load-use condition.
        applyStimulus(1, 7, 1, 1, 32'h700, 1, 7, 1, 7, 1, 1);
        #1;
        checkOutput("flush_stall", stall, 0);
        checkOutput("flush_bubble", bubble, 0);
        stepClock();
        checkOutput("flush_fwd_a", fwd_a, 0);
        checkOutput("flush_fwd_b", fwd_b, 0);

        // Async reset mid-stall: first load fwd_a=1 / fwd_res=0x88.
        applyStimulus(1, 8, 1, 0, 32'h88, 1, 8, 1, 0, 0, 0);
        stepClock();
        checkOutput("pre_rst_fwd_a", fwd_a, 1);
        checkOutput("pre_rst_fwd_res", fwd_res, 32'h88);
        applyStimulus(1, 9, 1, 1, 32'h900, 1, 0, 0, 9, 1, 0);
        #1;
        checkOutput("pre_rst_stall", stall, 1);
        rst = 1'b1;
        #1;
        checkOutput("async_rst_fwd_a", fwd_a, 0);
        checkOutput("async_rst_fwd_res", fwd_res, 0);
        rst = 1'b0;
        // The x8 producer was in the shadow slot; after reset it must be gone.
        applyStimulus(0, 0, 0, 0, 0, 1, 8, 1, 0, 0, 0);
        #1;
        checkOutput("post_rst_stall", stall, 0);
        stepClock();
        checkOutput("post_rst_fwd_a", fwd_a, 0);
        checkOutput("post_rst_fwd_res", fwd_res, 0);

`ifdef HAZARD_STATS_EN
        // Stall counter: reset, then three stalled cycles, then clear.
        rst = 1'b1;
        #1;
        checkOutput("cnt_reset", {16'd0, stall_count}, 0);
        rst = 1'b0;
        applyStimulus(1, 9, 1, 1, 32'h900, 1, 9, 1, 0, 0, 0);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("cnt_three", {16'd0, stall_count}, 3);
        stats_clr = 1'b1;
        stepClock();
        checkOutput("cnt_clear", {16'd0, stall_count}, 0);
        stats_clr = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepClock();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
